// File: rtl/jstk2_led_spi_tx.sv
// SPI master that sends one LED-color packet to a JSTK2 joystick module
// and decodes the joystick position and buttons from the MISO bytes it gets back.
module jstk2_led_spi_tx #(
  parameter int CLK_DIV   = 6,
  parameter int SETUP_CYC = 180,
  parameter int GAP_CYC   = 120,
  parameter int HOLD_CYC  = 300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] RGBcolor,
  output logic        busy,
  output logic        done,
  output logic        ss,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [1:0]  btn
);

  localparam int SU = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
  localparam int GP = (GAP_CYC < 1) ? 1 : GAP_CYC;
  localparam int HD = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
  localparam int BT = 2 * CLK_DIV;
  localparam int M1 = (SU > GP) ? SU : GP;
  localparam int M2 = (M1 > HD) ? M1 : HD;
  localparam int MX = (M2 > BT) ? M2 : BT;
  localparam int CW = $clog2(MX + 1);

  localparam logic [CW-1:0] SU_L = CW'(SU - 1);
  localparam logic [CW-1:0] GP_L = CW'(GP - 1);
  localparam logic [CW-1:0] HD_L = CW'(HD - 1);
  localparam logic [CW-1:0] LO_L = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BT_L = CW'(BT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP,
    HOLD
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [2:0]    byte_idx, byte_n;
  logic [39:0]   tx, tx_n;
  logic [39:0]   rx, rx_n;
  logic          busy_n, done_n, ss_n;
  logic          sclk_n, mosi_n;
  logic [9:0]    x_n, y_n;
  logic [1:0]    btn_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    tx_n    = tx;
    rx_n    = rx;
    busy_n  = busy;
    done_n  = 1'b0;
    ss_n    = ss;
    sclk_n  = sclk;
    mosi_n  = mosi;
    x_n     = x_pos;
    y_n     = y_pos;
    btn_n   = btn;
    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        ss_n   = 1'b1;
        sclk_n = 1'b0;
        mosi_n = 1'b0;
        // the done cycle sits in IDLE with busy still high
        if (start && !busy) begin
          state_n = SETUP;
          cnt_n   = '0;
          byte_n  = '0;
          busy_n  = 1'b1;
          ss_n    = 1'b0;
          tx_n    = {8'h84, RGBcolor, 8'h00};
          rx_n    = '0;
        end
      end
      SETUP: begin
        if (cnt == SU_L) begin
          state_n = SHIFT;
          cnt_n   = '0;
          bit_n   = 3'd7;
          mosi_n  = tx[39];
          tx_n    = {tx[38:0], 1'b0};
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SHIFT: begin
        cnt_n = cnt + 1'b1;
        if (cnt == LO_L) begin
          sclk_n = 1'b1;
          rx_n   = {rx[38:0], miso};
        end
        if (cnt == BT_L) begin
          sclk_n = 1'b0;
          cnt_n  = '0;
          if (bit_idx == 3'd0) begin
            mosi_n = 1'b0;
            if (byte_idx == 3'd4) begin
              state_n = HOLD;
              ss_n    = 1'b1;
            end else begin
              state_n = GAP;
            end
          end else begin
            bit_n  = bit_idx - 1'b1;
            mosi_n = tx[39];
            tx_n   = {tx[38:0], 1'b0};
          end
        end
      end
      GAP: begin
        if (cnt == GP_L) begin
          state_n = SHIFT;
          cnt_n   = '0;
          bit_n   = 3'd7;
          byte_n  = byte_idx + 1'b1;
          mosi_n  = tx[39];
          tx_n    = {tx[38:0], 1'b0};
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (cnt == HD_L) begin
          state_n = IDLE;
          done_n  = 1'b1;
          x_n     = {rx[25:24], rx[39:32]};
          y_n     = {rx[9:8], rx[23:16]};
          btn_n   = rx[1:0];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx       <= '0;
      rx       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ss       <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      x_pos    <= '0;
      y_pos    <= '0;
      btn      <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      tx       <= tx_n;
      rx       <= rx_n;
      busy     <= busy_n;
      done     <= done_n;
      ss       <= ss_n;
      sclk     <= sclk_n;
      mosi     <= mosi_n;
      x_pos    <= x_n;
      y_pos    <= y_n;
      btn      <= btn_n;
    end
  end

endmodule

// File: tb/tb_jstk2_led_spi_tx.sv
// Directed bench for jstk2_led_spi_tx: packet bytes, MISO decode,
// start filtering, mid-packet reset and back-to-back packets.
module tb_jstk2_led_spi_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] RGBcolor;
  logic        busy, done, ss, sclk, mosi, miso;
  logic [9:0]  x_pos, y_pos;
  logic [1:0]  btn;

  int checks = 0;
  int errors = 0;

  jstk2_led_spi_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .RGBcolor (RGBcolor),
    .busy     (busy),
    .done     (done),
    .ss       (ss),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .btn      (btn)
  );

  always #5 clk = ~clk;

  localparam logic [39:0] MISO_A = 40'h5A_02_C3_01_03;
  localparam logic [39:0] MISO_B = 40'hFF_FC_00_00_02;

  logic [39:0] miso_bits = MISO_A;
  logic [39:0] cap = '0;
  logic        sclk_q = 1'b0;
  int edges = 0, pk = 0, busy_cyc = 0, done_cyc = 0;
  int ss_run = 0, ss_last_run = 0, ss_bad = 0;

  // observe the bus at each clk edge (pre-edge values)
  always @(posedge clk) begin
    sclk_q <= sclk;
    if (sclk === 1'b1 && sclk_q === 1'b0) begin
      edges <= edges + 1;
      pk    <= pk + 1;
      cap   <= {cap[38:0], mosi};
    end
    if (ss === 1'b1) pk <= 0;
    if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
    if (done === 1'b1) done_cyc <= done_cyc + 1;
    if (ss === 1'b1 && (mosi !== 1'b0 || sclk !== 1'b0))
      ss_bad <= ss_bad + 1;
    if (ss === 1'b1) begin
      ss_run <= ss_run + 1;
    end else begin
      if (ss_run != 0) ss_last_run <= ss_run;
      ss_run <= 0;
    end
  end

  // slave model: next MISO bit presented during the low phase
  always @(negedge clk) begin
    if (pk < 40) miso = miso_bits[39 - pk];
    else miso = 1'b0;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {63'd0, done}, 64'd1);
    @(negedge clk);
    chk({tag, "_pulse"}, {62'd0, done, busy}, 64'd0);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [9:0] x,
                         input logic [9:0] y, input logic [1:0] b);
    chk({tag, "_x"}, {54'd0, x_pos}, {54'd0, x});
    chk({tag, "_y"}, {54'd0, y_pos}, {54'd0, y});
    chk({tag, "_btn"}, {62'd0, btn}, {62'd0, b});
  endtask

  int e0, b0, d0, n;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b1;
    RGBcolor = 24'h7F0000;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {59'd0, busy, done, ss, sclk, mosi}, 64'b00100);
    chk_out("rst", 10'h0, 10'h0, 2'b00);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_start_ignored", {62'd0, busy, ss}, 64'b01);

    // packet A: red, MISO table A
    e0 = edges; b0 = busy_cyc; d0 = done_cyc;
    pulse_start();
    chk("A_busy_ss", {62'd0, busy, ss}, 64'b10);
    wait_done("A_done");
    chk("A_bytes", {24'd0, cap}, {24'd0, 40'h84_7F_00_00_00});
    chk("A_edges", edges - e0, 40);
    chk("A_busy_len", busy_cyc - b0, 180 + 4*120 + 40*2*6 + 300 + 1);
    chk("A_done_cnt", done_cyc - d0, 1);
    chk_out("A", 10'h25A, 10'h1C3, 2'b11);

    // packet B: color changes after start, start pulsed in SHIFT
    miso_bits = MISO_B;
    RGBcolor  = 24'h123456;
    e0 = edges; d0 = done_cyc;
    pulse_start();
    RGBcolor = 24'h00007F;
    n = 0;
    while (sclk !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("B_sclk_seen", {63'd0, sclk}, 64'd1);
    pulse_start();
    wait_done("B_done");
    chk("B_bytes", {24'd0, cap}, {24'd0, 40'h84_12_34_56_00});
    chk_out("B", 10'h0FF, 10'h000, 2'b10);
    repeat (1600) @(negedge clk);
    chk("B_one_pkt_edges", edges - e0, 40);
    chk("B_one_pkt_done", done_cyc - d0, 1);
    chk("B_idle", {62'd0, busy, ss}, 64'b01);

    // packet C: reset while byte 2 is shifting
    miso_bits = MISO_A;
    RGBcolor  = 24'h00FF80;
    d0 = done_cyc;
    pulse_start();
    n = 0;
    while (pk < 17 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("C_reached_byte2", {63'd0, pk >= 17}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("C_abort", {60'd0, ss, sclk, busy, done}, 64'b1000);
    chk_out("C_abort", 10'h0, 10'h0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("C_no_done", done_cyc - d0, 0);

    // packet D: full packet after the abort
    e0 = edges;
    pulse_start();
    wait_done("D_done");
    chk("D_bytes", {24'd0, cap}, {24'd0, 40'h84_00_FF_80_00});
    chk("D_edges", edges - e0, 40);
    chk_out("D", 10'h25A, 10'h1C3, 2'b11);

    // packets E then F back-to-back
    miso_bits = MISO_B;
    RGBcolor  = 24'hA1B2C3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("E_done", {63'd0, done}, 64'd1);
    @(negedge clk);
    chk("E_first_idle", {62'd0, done, busy}, 64'd0);
    chk("E_bytes", {24'd0, cap}, {24'd0, 40'h84_A1_B2_C3_00});
    chk_out("E", 10'h0FF, 10'h000, 2'b10);
    miso_bits = MISO_A;
    RGBcolor  = 24'h0F1E2D;
    e0 = edges;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("F_accepted", {62'd0, busy, ss}, 64'b10);
    wait_done("F_done");
    chk("F_ss_gap", {63'd0, ss_last_run >= 300}, 64'd1);
    chk("F_bytes", {24'd0, cap}, {24'd0, 40'h84_0F_1E_2D_00});
    chk("F_edges", edges - e0, 40);
    chk_out("F", 10'h25A, 10'h1C3, 2'b11);

    chk("ss_high_quiet", ss_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jstk2_led_spi_tx.md
JSTK2_LED_SPI_TX -- requirements
Module: jstk2_led_spi_tx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 6, giving the clk cycles per SCLK half-period (1 MHz SCLK at 12 MHz clk).
REQ-002 The block SHALL have parameter SETUP_CYC, default 180, giving the clk cycles from SS falling to the first SCLK edge (15 us).
REQ-003 The block SHALL have parameter GAP_CYC, default 120, giving the clk cycles between bytes with SS held low (10 us).
REQ-004 The block SHALL have parameter HOLD_CYC, default 300, giving the clk cycles SS is held high after a packet before done (25 us).
REQ-005 Port clk SHALL be an input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 Port rst_n SHALL be an input, 1 bit: reset, synchronous and active-low.
REQ-007 Port start SHALL be an input, 1 bit: a one-cycle request to send one LED-command packet.
REQ-008 Port RGBcolor SHALL be an input, 24 bits, laid out as {red[7:0], green[7:0], blue[7:0]}.
REQ-009 Port busy SHALL be an output, 1 bit: high from the start-accept cycle until the done cycle inclusive.
REQ-010 Port done SHALL be an output, 1 bit: a one-cycle pulse at the end of the packet.
REQ-011 Port ss SHALL be an output, 1 bit: active-low SPI slave select.
REQ-012 Port sclk SHALL be an output, 1 bit: SPI clock, mode 0, idle low.
REQ-013 Port mosi SHALL be an output, 1 bit: SPI data out, MSB first.
REQ-014 Port miso SHALL be an input, 1 bit: SPI data in, sampled by the block.
REQ-015 Port x_pos SHALL be an output, 10 bits: the joystick X sample.
REQ-016 Port y_pos SHALL be an output, 10 bits: the joystick Y sample.
REQ-017 Port btn SHALL be an output, 2 bits, laid out as {trigger, joystick}.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, SETUP, SHIFT, GAP and HOLD.
REQ-019 In IDLE, start=1 SHALL latch RGBcolor, set busy=1 on the next cycle, drive ss low and enter SETUP.
REQ-020 start SHALL be ignored while busy=1; no queueing.
REQ-021 The packet SHALL be 5 bytes: 0x84, red, green, blue, 0x00.
REQ-022 Later changes to RGBcolor SHALL NOT affect a packet in flight.
REQ-023 SETUP SHALL last SETUP_CYC cycles with ss=0 and sclk=0; the FSM then enters SHIFT at byte index 0.
REQ-024 In SHIFT, each bit SHALL be a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
REQ-025 mosi SHALL update at the first cycle of each low phase.
REQ-026 miso SHALL be sampled on the cycle sclk goes high and shifted into the receive byte MSB first.
REQ-027 After the high phase of bit 0, sclk SHALL return low.
REQ-028 After the last bit, the FSM SHALL enter GAP for byte indices 0-3 and HOLD after byte index 4.
REQ-029 GAP SHALL last GAP_CYC cycles with ss=0 and sclk=0, then return to SHIFT with byte index +1.
REQ-030 On HOLD entry, ss SHALL go high; HOLD SHALL last HOLD_CYC cycles.
REQ-031 On the last HOLD cycle, the block SHALL pulse done=1, update the outputs, and return to IDLE with busy=0 on the next cycle.
REQ-032 Output update at done: x_pos SHALL be {rx1[1:0], rx0}, y_pos SHALL be {rx3[1:0], rx2}, btn SHALL be rx4[1:0]; all other received bits are discarded.
REQ-033 x_pos, y_pos and btn SHALL hold their values between packets.
REQ-034 mosi SHALL be 0 whenever ss=1.
REQ-035 sclk SHALL toggle only in SHIFT.
REQ-036 Counters SHALL be sized for the largest of the parameters.
REQ-037 A zero-valued SETUP_CYC, GAP_CYC or HOLD_CYC SHALL be treated as 1.
REQ-038 When start is accepted on the cycle done deasserts, i.e. the first IDLE cycle, back-to-back packets SHALL be legal.

Reset
REQ-039 While rst_n=0 at a clk edge, the block SHALL force state=IDLE, busy=0, done=0, ss=1, sclk=0, mosi=0, x_pos=0, y_pos=0 and btn=0.
REQ-040 Reset mid-packet SHALL abort immediately: ss goes high on the next edge, no done, and x_pos, y_pos and btn are cleared.
REQ-041 start asserted during reset SHALL be ignored.

Verification
REQ-042 Bench SHALL cover: RGBcolor=24'h7F0000 with start -> MOSI bytes 84,7F,00,00,00 MSB first; 40 SCLK rising edges; done one cycle; busy length = SETUP+4*GAP+40*2*CLK_DIV+HOLD+1 cycles.
REQ-043 Bench SHALL cover: a MISO model returning 0x5A,0x02,0xC3,0x01,0x03 -> x_pos=10'h25A, y_pos=10'h1C3, btn=2'b11.
REQ-044 Bench SHALL cover: RGBcolor changed to 24'h00007F one cycle after start -> the packet still carries the original color.
REQ-045 Bench SHALL cover: start pulsed during SHIFT -> ignored; exactly one packet is sent.
REQ-046 Bench SHALL cover: rst_n low during byte 2 -> next edge ss=1, sclk=0, busy=0, no done; a following start sends a full packet.
REQ-047 Bench SHALL cover: start on the first IDLE cycle after done -> ss stays high at least HOLD_CYC cycles between packets, and the second packet is correct.
